// File: rtl/byte_stream_ram_loader.sv
// byte_stream_ram_loader: packs a valid/ready byte stream into DATA_W-bit words,
// writes them to consecutive RAM addresses starting at BASE_ADDR and, optionally,
// reads the image back and compares a readback checksum with the write checksum.
module byte_stream_ram_loader #(
   parameter int                DATA_W     = 32,
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int                MAX_WORDS  = 1024,
   parameter bit                BIG_ENDIAN = 1'b1,
   parameter bit                VERIFY     = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_cs,
   output logic              mem_we,
   output logic              mem_oe,
   output logic [ADDR_W-1:0] words_written,
   output logic              busy,
   output logic              finished,
   output logic              error
);

   localparam int BPW    = DATA_W / 8;
   localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
      S_VERIFY_RD,
      S_VERIFY_CMP,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
   logic [DATA_W-1:0] word_buf_q, word_buf_d;
   logic              last_seen_q, last_seen_d;
   logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
   logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
   logic [DATA_W-1:0] wsum_q, wsum_d;
   logic [DATA_W-1:0] rsum_q, rsum_d;

   logic              byte_ready_q, byte_ready_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_cs_q, mem_cs_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_oe_q, mem_oe_d;
   logic              busy_q, busy_d;
   logic              finished_q, finished_d;
   logic              error_q, error_d;

   logic              accept;
   logic [DATA_W-1:0] rsum_next;
   int                lane;

   // Next-state and next-output computation for the load/verify sequencer.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves a latch.
      state_d      = state_q;
      byte_idx_d   = byte_idx_q;
      word_buf_d   = word_buf_q;
      last_seen_d  = last_seen_q;
      word_cnt_d   = word_cnt_q;
      rd_idx_d     = rd_idx_q;
      wsum_d       = wsum_q;
      rsum_d       = rsum_q;
      byte_ready_d = byte_ready_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_cs_d     = mem_cs_q;
      mem_we_d     = mem_we_q;
      mem_oe_d     = mem_oe_q;
      busy_d       = busy_q;
      finished_d   = finished_q;
      error_d      = error_q;

      accept    = byte_valid & byte_ready_q;
      lane      = BIG_ENDIAN ? (BPW - 1 - int'(byte_idx_q)) : int'(byte_idx_q);
      rsum_next = rsum_q + mem_rdata;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               word_cnt_d   = '0;
               rd_idx_d     = '0;
               wsum_d       = '0;
               rsum_d       = '0;
               byte_idx_d   = '0;
               word_buf_d   = '0;
               last_seen_d  = 1'b0;
               error_d      = 1'b0;
               finished_d   = 1'b0;
               busy_d       = 1'b1;
               byte_ready_d = 1'b1;
               state_d      = S_COLLECT;
            end
         end

         S_COLLECT: begin
            if (accept) begin
               word_buf_d[8*lane +: 8] = byte_in;
               if (byte_last || byte_idx_q == BIDX_W'(BPW - 1)) begin
                  byte_ready_d = 1'b0;
                  last_seen_d  = byte_last;
                  if (word_cnt_q == ADDR_W'(MAX_WORDS)) begin
                     // Image larger than the RAM window: stop without a memory cycle.
                     error_d    = 1'b1;
                     busy_d     = 1'b0;
                     finished_d = 1'b1;
                     state_d    = S_DONE;
                  end else begin
                     mem_cs_d    = 1'b1;
                     mem_we_d    = 1'b1;
                     mem_oe_d    = 1'b0;
                     mem_addr_d  = BASE_ADDR + word_cnt_q;
                     mem_wdata_d = word_buf_d;
                     state_d     = S_WRITE;
                  end
               end else begin
                  byte_idx_d = byte_idx_q + BIDX_W'(1);
               end
            end
         end

         S_WRITE: begin
            mem_cs_d   = 1'b0;
            mem_we_d   = 1'b0;
            word_cnt_d = word_cnt_q + ADDR_W'(1);
            wsum_d     = wsum_q + mem_wdata_q;
            word_buf_d = '0;
            byte_idx_d = '0;
            if (!last_seen_q) begin
               byte_ready_d = 1'b1;
               state_d      = S_COLLECT;
            end else if (VERIFY) begin
               mem_cs_d   = 1'b1;
               mem_oe_d   = 1'b1;
               mem_addr_d = BASE_ADDR + rd_idx_q;
               state_d    = S_VERIFY_RD;
            end else begin
               busy_d     = 1'b0;
               finished_d = 1'b1;
               state_d    = S_DONE;
            end
         end

         S_VERIFY_RD: begin
            mem_cs_d = 1'b0;
            mem_oe_d = 1'b0;
            state_d  = S_VERIFY_CMP;
         end

         S_VERIFY_CMP: begin
            rsum_d   = rsum_next;
            rd_idx_d = rd_idx_q + ADDR_W'(1);
            if (rd_idx_d == word_cnt_q) begin
               error_d    = (rsum_next != wsum_q);
               busy_d     = 1'b0;
               finished_d = 1'b1;
               state_d    = S_DONE;
            end else begin
               mem_cs_d   = 1'b1;
               mem_oe_d   = 1'b1;
               mem_addr_d = BASE_ADDR + rd_idx_d;
               state_d    = S_VERIFY_RD;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and output registers; reset aborts any load in flight.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      if (rst) begin
         state_q      <= S_IDLE;
         byte_idx_q   <= '0;
         word_buf_q   <= '0;
         last_seen_q  <= 1'b0;
         word_cnt_q   <= '0;
         rd_idx_q     <= '0;
         wsum_q       <= '0;
         rsum_q       <= '0;
         byte_ready_q <= 1'b0;
         mem_addr_q   <= BASE_ADDR;
         mem_wdata_q  <= '0;
         mem_cs_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_oe_q     <= 1'b0;
         busy_q       <= 1'b0;
         finished_q   <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_idx_q   <= byte_idx_d;
         word_buf_q   <= word_buf_d;
         last_seen_q  <= last_seen_d;
         word_cnt_q   <= word_cnt_d;
         rd_idx_q     <= rd_idx_d;
         wsum_q       <= wsum_d;
         rsum_q       <= rsum_d;
         byte_ready_q <= byte_ready_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_cs_q     <= mem_cs_d;
         mem_we_q     <= mem_we_d;
         mem_oe_q     <= mem_oe_d;
         busy_q       <= busy_d;
         finished_q   <= finished_d;
         error_q      <= error_d;
      end
   end

   assign byte_ready    = byte_ready_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_cs        = mem_cs_q;
   assign mem_we        = mem_we_q;
   assign mem_oe        = mem_oe_q;
   assign words_written = word_cnt_q;
   assign busy          = busy_q;
   assign finished      = finished_q;
   assign error         = error_q;

endmodule

// File: tb/tb_byte_stream_ram_loader.sv
// Testbench for byte_stream_ram_loader. Three instances cover the parameter
// corners: inst 0 big-endian with verify, inst 1 little-endian without verify,
// inst 2 big-endian without verify and a two-word capacity. Expected writes are
// queued by the stimulus; a monitor pops and compares each observed write.
module tb_byte_stream_ram_loader;

   localparam int N = 3;

   typedef struct {
      int          inst;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   logic flip_en;

   logic        start_s      [N];
   logic        byte_valid_s [N];
   logic        byte_last_s  [N];
   logic [7:0]  byte_in_s    [N];
   logic        byte_ready_s [N];
   logic        mem_cs_s     [N];
   logic        mem_we_s     [N];
   logic        mem_oe_s     [N];
   logic        busy_s       [N];
   logic        finished_s   [N];
   logic        error_s      [N];
   logic [31:0] mem_addr_s   [N];
   logic [31:0] mem_wdata_s  [N];
   logic [31:0] ww_s         [N];

   int  n_checks = 0;
   int  n_errors = 0;
   int  rd_total [N] = '{default: 0};
   wr_t exp_q [$];

   always #5 clk = ~clk;

   // One DUT plus a registered-read RAM model per parameter corner.
   for (genvar g = 0; g < N; g++) begin : g_dut
      logic [31:0] ram [16];
      logic [31:0] rdata;

      byte_stream_ram_loader #(
         .DATA_W    (32),
         .ADDR_W    (32),
         .BASE_ADDR (32'h0),
         .MAX_WORDS ((g == 2) ? 2 : 1024),
         .BIG_ENDIAN(g != 1),
         .VERIFY    (g == 0)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .start        (start_s[g]),
         .byte_in      (byte_in_s[g]),
         .byte_valid   (byte_valid_s[g]),
         .byte_last    (byte_last_s[g]),
         .byte_ready   (byte_ready_s[g]),
         .mem_addr     (mem_addr_s[g]),
         .mem_wdata    (mem_wdata_s[g]),
         .mem_rdata    (rdata),
         .mem_cs       (mem_cs_s[g]),
         .mem_we       (mem_we_s[g]),
         .mem_oe       (mem_oe_s[g]),
         .words_written(ww_s[g]),
         .busy         (busy_s[g]),
         .finished     (finished_s[g]),
         .error        (error_s[g])
      );

      // RAM: write on cs&we, read data valid the cycle after cs&oe; optional bit-0 flip of word @1.
      always @(posedge clk) begin
         if (mem_cs_s[g] && mem_we_s[g])
            ram[mem_addr_s[g][3:0]] <= mem_wdata_s[g];
         if (mem_cs_s[g] && mem_oe_s[g])
            rdata <= ram[mem_addr_s[g][3:0]] ^
                     ((g == 0 && flip_en && mem_addr_s[g] == 32'd1) ? 32'h1 : 32'h0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %h, required %h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input int g, input logic [31:0] addr, input logic [31:0] data);
      wr_t item;
      item.inst = g;
      item.addr = addr;
      item.data = data;
      exp_q.push_back(item);
   endtask

   task automatic pulse_start(input int g);
      start_s[g] = 1'b1;
      @(negedge clk);
      start_s[g] = 1'b0;
   endtask

   // Present one byte at a negedge and hold it until a rising edge sees byte_ready.
   task automatic send_byte(input int g, input logic [7:0] b, input logic last, input bit gaps);
      int waited = 0;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      byte_in_s[g]    = b;
      byte_last_s[g]  = last;
      byte_valid_s[g] = 1'b1;
      while (!byte_ready_s[g] && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!byte_ready_s[g])
         check($sformatf("byte_accept_timeout_inst%0d", g), {31'b0, byte_ready_s[g]}, 32'd1);
      else
         @(negedge clk);
      byte_valid_s[g] = 1'b0;
      byte_last_s[g]  = 1'b0;
   endtask

   task automatic send_seq(input int g, input logic [7:0] first, input int n,
                           input bit mark_last, input bit gaps);
      for (int i = 0; i < n; i++)
         send_byte(g, 8'(int'(first) + i), mark_last && (i == n - 1), gaps);
   endtask

   // Wait (bounded) for finished, then compare the final status against expectations.
   task automatic finish_check(input string tag, input int g, input logic err,
                               input int ww, input int reads, input int rd_base);
      int c = 0;
      while (!finished_s[g] && c < 200) begin
         @(negedge clk);
         c++;
      end
      check({tag, "_finished"},   {31'b0, finished_s[g]},   32'd1);
      check({tag, "_busy"},       {31'b0, busy_s[g]},       32'd0);
      check({tag, "_error"},      {31'b0, error_s[g]},      {31'b0, err});
      check({tag, "_words"},      ww_s[g],                  32'(ww));
      check({tag, "_reads"},      32'(rd_total[g] - rd_base), 32'(reads));
      check({tag, "_ready_done"}, {31'b0, byte_ready_s[g]}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag, input int g);
      check({tag, "_busy"},     {31'b0, busy_s[g]},       32'd0);
      check({tag, "_finished"}, {31'b0, finished_s[g]},   32'd0);
      check({tag, "_error"},    {31'b0, error_s[g]},      32'd0);
      check({tag, "_ready"},    {31'b0, byte_ready_s[g]}, 32'd0);
      check({tag, "_cs"},       {31'b0, mem_cs_s[g]},     32'd0);
      check({tag, "_we"},       {31'b0, mem_we_s[g]},     32'd0);
      check({tag, "_oe"},       {31'b0, mem_oe_s[g]},     32'd0);
      check({tag, "_addr"},     mem_addr_s[g],            32'h0);
      check({tag, "_wdata"},    mem_wdata_s[g],           32'h0);
      check({tag, "_words"},    ww_s[g],                  32'd0);
   endtask

   // Monitor: every write cycle is matched against the head of the expectation queue.
   initial begin
      wr_t item;
      forever begin
         @(negedge clk);
         for (int g = 0; g < N; g++) begin
            if (mem_cs_s[g] && mem_oe_s[g]) rd_total[g]++;
            if (mem_cs_s[g])
               check($sformatf("ready_low_in_mem_cycle_inst%0d", g), {31'b0, byte_ready_s[g]}, 32'd0);
            if (mem_cs_s[g] && mem_we_s[g]) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_write inst%0d: actual addr %h data %h, required no write",
                           g, mem_addr_s[g], mem_wdata_s[g]);
               end else begin
                  item = exp_q.pop_front();
                  check("write_inst", 32'(g), 32'(item.inst));
                  check($sformatf("write_addr_inst%0d", g), mem_addr_s[g], item.addr);
                  check($sformatf("write_data_inst%0d", g), mem_wdata_s[g], item.data);
               end
            end
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rd0;
      rst     = 1'b1;
      flip_en = 1'b0;
      for (int g = 0; g < N; g++) begin
         start_s[g]      = 1'b0;
         byte_valid_s[g] = 1'b0;
         byte_last_s[g]  = 1'b0;
         byte_in_s[g]    = 8'h00;
      end
      repeat (3) @(negedge clk);
      for (int g = 0; g < N; g++) check_reset_outputs($sformatf("reset_inst%0d", g), g);
      rst = 1'b0;
      @(negedge clk);

      // Big-endian, no verify, exactly two words (fits MAX_WORDS=2).
      expect_wr(2, 32'd0, 32'h01020304);
      expect_wr(2, 32'd1, 32'h05060708);
      rd0 = rd_total[2];
      pulse_start(2);
      send_seq(2, 8'h01, 8, 1'b1, 1'b0);
      finish_check("be_noverify", 2, 1'b0, 2, 0, rd0);

      // Little-endian packing of the same bytes.
      expect_wr(1, 32'd0, 32'h04030201);
      expect_wr(1, 32'd1, 32'h08070605);
      rd0 = rd_total[1];
      pulse_start(1);
      send_seq(1, 8'h01, 8, 1'b1, 1'b0);
      finish_check("le_noverify", 1, 1'b0, 2, 0, rd0);

      // Partial last word, zero-filled, verified against a correct RAM.
      expect_wr(0, 32'd0, 32'h01020304);
      expect_wr(0, 32'd1, 32'h05000000);
      rd0 = rd_total[0];
      pulse_start(0);
      send_seq(0, 8'h01, 5, 1'b1, 1'b0);
      finish_check("partial_verify", 0, 1'b0, 2, 2, rd0);

      // Same image, RAM corrupts word @1 on readback: checksum mismatch.
      flip_en = 1'b1;
      expect_wr(0, 32'd0, 32'h01020304);
      expect_wr(0, 32'd1, 32'h05000000);
      rd0 = rd_total[0];
      pulse_start(0);
      send_seq(0, 8'h01, 5, 1'b1, 1'b0);
      finish_check("verify_mismatch", 0, 1'b1, 2, 2, rd0);
      flip_en = 1'b0;

      // Gappy stream of 12 bytes: three full words, none lost or duplicated.
      expect_wr(0, 32'd0, 32'h11121314);
      expect_wr(0, 32'd1, 32'h15161718);
      expect_wr(0, 32'd2, 32'h191a1b1c);
      rd0 = rd_total[0];
      pulse_start(0);
      send_seq(0, 8'h11, 12, 1'b1, 1'b1);
      finish_check("gaps_verify", 0, 1'b0, 3, 3, rd0);

      // Overflow: third word hits MAX_WORDS=2, no third write, error flagged.
      expect_wr(2, 32'd0, 32'h01020304);
      expect_wr(2, 32'd1, 32'h05060708);
      rd0 = rd_total[2];
      pulse_start(2);
      send_seq(2, 8'h01, 12, 1'b1, 1'b0);
      finish_check("overflow", 2, 1'b1, 2, 0, rd0);

      // Reset mid-stream: outputs return to reset values at once, then reload cleanly.
      expect_wr(0, 32'd0, 32'h21222324);
      pulse_start(0);
      send_seq(0, 8'h21, 6, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check_reset_outputs("midload_reset", 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      expect_wr(0, 32'd0, 32'ha0a1a2a3);
      rd0 = rd_total[0];
      pulse_start(0);
      send_seq(0, 8'ha0, 4, 1'b1, 1'b0);
      finish_check("reload_after_reset", 0, 1'b0, 1, 1, rd0);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/byte_stream_ram_loader.md
Name: byte_stream_ram_loader

Overview:
Synthesizable loader that fills program/data RAM from a byte stream. It is the hardware successor to the simulation-only file loader.
- Accepts bytes over a valid/ready handshake and packs them into DATA_W-bit words, with selectable byte order.
- Writes each word to consecutive RAM addresses through the existing cs/we/oe memory interface.
- Optionally reads the image back and checks it against a running checksum before raising finished.
- Sits between the host/UART byte source and the unified memory, ahead of CPU reset release.

Parameters:
DATA_W, 32, memory word width; multiple of 8; BPW = DATA_W/8
ADDR_W, 32, memory address width
BASE_ADDR, 0, first word address written
MAX_WORDS, 1024, capacity limit in words
BIG_ENDIAN, 1, 1: first byte lands in MSB; 0: first byte lands in LSB
VERIFY, 1, 1: readback checksum pass after load; 0: skip

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  1-cycle pulse; begins a load; honoured only in IDLE or DONE
byte_in  in  8  stream byte
byte_valid  in  1  byte_in/byte_last valid
byte_last  in  1  marks the final byte of the image
byte_ready  out  1  loader accepts a byte this cycle
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data; valid the cycle after a cs&oe request
mem_cs  out  1  chip select
mem_we  out  1  write enable
mem_oe  out  1  output enable
words_written  out  ADDR_W  words committed in the current/last load
busy  out  1  load or verify in progress
finished  out  1  load (and verify) complete; held until next start
error  out  1  checksum mismatch or overflow; valid when finished=1

Behaviour:
- Reset: all outputs 0 except mem_addr=BASE_ADDR. State=IDLE. Internal counters, checksums and the byte index are cleared. Asserting rst mid-load aborts immediately; no further memory cycles are issued.
- All outputs are registered.
- Byte handshake: a transfer occurs on byte_valid & byte_ready at a rising edge. byte_ready=1 only in COLLECT.
- IDLE/DONE + start: clear word_cnt, wsum, rsum, byte_idx, error and finished. Set busy=1 and go to COLLECT.
- COLLECT:
  - Each accepted byte is placed at lane byte_idx. With BIG_ENDIAN the lane is bits [DATA_W-1-8*byte_idx -: 8]; otherwise it is [8*byte_idx +: 8].
  - On accepting byte_idx==BPW-1, or any byte with byte_last=1, go to WRITE. Unfilled lanes are zero.
  - A held byte_valid with no transfer does not advance state.
- WRITE (1 cycle):
  - Drive mem_cs=1, mem_we=1, mem_oe=0, mem_addr=BASE_ADDR+word_cnt, mem_wdata=packed word.
  - Then word_cnt++ and wsum += word (mod 2^DATA_W). Clear the word buffer and byte_idx.
  - If last was seen: go to VERIFY_RD when VERIFY=1, else DONE. Otherwise return to COLLECT.
- Overflow: if word_cnt==MAX_WORDS on entry to WRITE, no memory cycle is issued, error=1 and the state goes to DONE. Remaining stream bytes are not accepted (byte_ready=0).
- VERIFY_RD:
  - Drive mem_cs=1, mem_oe=1, mem_we=0, mem_addr=BASE_ADDR+rd_idx, then go to VERIFY_CMP.
- VERIFY_CMP:
  - Deassert cs/oe and sample rsum += mem_rdata.
  - Increment rd_idx. If rd_idx==word_cnt, go to DONE with error = (rsum != wsum); else return to VERIFY_RD.
  - Timing: 2 cycles per word.
- DONE: busy=0, finished=1; outputs hold. A new start restarts the load.
- start while busy is ignored.
- words_written tracks word_cnt live.

Test Plan:
- BE, VERIFY=0: start, then bytes 01..08 (last on 08) -> writes 0x01020304 @0, 0x05060708 @1; finished=1, error=0, words_written=2.
- BIG_ENDIAN=0: same bytes -> 0x04030201 @0, 0x08070605 @1.
- Partial word, BE: 5 bytes 01..05 -> 0x05000000 @1; with VERIFY=1 and a correct RAM model, 2 reads, error=0.
- Verify mismatch: RAM model flips bit 0 of word @1 on read -> finished=1, error=1.
- Backpressure/gaps: byte_valid toggling randomly with 12 bytes -> identical 3 words; byte_ready low during WRITE/VERIFY; no byte lost or duplicated.
- MAX_WORDS=2, 12 bytes -> only @0 and @1 written, error=1. Separately, rst pulsed mid-stream -> outputs return to reset values at once; a following start reloads cleanly from BASE_ADDR.
